lsu_mem_ctrl: RTL and testbench

//  Load/store memory controller in the MEM stage. Accepts one access per handshake and issues a

---
 rtl/lsu_mem_ctrl_if.sv | 40 ++++
 rtl/lsu_mem_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the pipeline-side request/response signals and the data-memory
// port of the load/store memory controller.
//   slave  : the controller itself
//   master : the pipeline plus data memory (or a testbench standing in for both)
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        dm_err;

  logic        resp_valid;
  logic [31:0] dataout;
  logic [31:0] resp_addr;
  logic [4:0]  resp_mem_op;
  logic        resp_err;
  logic        resp_misalign;

  modport slave (
    input  req_valid, mem_op, addr, wdata, dm_ack, dm_rdata, dm_err,
    output req_ready, stall, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
           resp_valid, dataout, resp_addr, resp_mem_op, resp_err, resp_misalign
  );

  modport master (
    output req_valid, mem_op, addr, wdata, dm_ack, dm_rdata, dm_err,
    input  req_ready, stall, dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
           resp_valid, dataout, resp_addr, resp_mem_op, resp_err, resp_misalign
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: takes one access per handshake, issues a
// word-aligned request to data memory, waits for the ack (or times out) and
// returns the raw read word with the original addr/mem_op for the downstream
// load aligner. Stores get byte strobes and lane-shifted write data here.
//
// mem_op: [1:0] size (0 byte, 1 half, 2 word), [2] signed, [3] load, [4] store.
// A size code of 3 is handled like a word.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined     -> accesses crossing a word boundary are rejected without a
//                  memory request and answered with resp_misalign=1.
//   not defined -> such accesses go out word-aligned, strobes past lane 3
//                  are dropped, resp_misalign stays 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a request, no memory access outstanding
// ST_WAIT | dm_req held high, waiting for dm_ack or the timeout
// ST_RESP | resp_valid pulse, response registers hold the result
module lsu_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input logic           clk,
  input logic           rst_n,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [4:0]       op_q;

  logic             dm_req_q;
  logic             dm_we_q;
  logic [31:0]      dm_addr_q;
  logic [3:0]       dm_wstrb_q;
  logic [31:0]      dm_wdata_q;

  logic [31:0]      dataout_q;
  logic [31:0]      resp_addr_q;
  logic [4:0]       resp_op_q;
  logic             resp_err_q;

  logic [1:0]       sh;
  logic             req_is_store;
  logic             req_is_mem;
  logic             req_misalign;
  logic [3:0]       st_wstrb;
  logic [31:0]      st_wdata;
  logic             req_ready;
  logic             resp_valid;
  logic             accept;
  logic             timeout_hit;

  assign sh           = bus.addr[1:0];
  assign req_is_store = bus.mem_op[4];
  assign req_is_mem   = bus.mem_op[4] | bus.mem_op[3];

`ifdef LSU_MISALIGN_CHECK_EN
  // Reject any half or word that would spill over the word boundary.
  assign req_misalign = ((bus.mem_op[1:0] == MEM_HALF) && (sh == 2'b11)) ||
                        (bus.mem_op[1] && (sh != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  // Store lane placement: strobes shifted to the byte offset, data replicated
  // so that the addressed lanes always carry the right bytes.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = 32'h0;
    if (req_is_store) begin
      case (bus.mem_op[1:0])
        MEM_BYTE: begin
          st_wstrb = 4'b0001 << sh;
          st_wdata = {4{bus.wdata[7:0]}};
        end
        MEM_HALF: begin
          st_wstrb = 4'b0011 << sh;
          st_wdata = sh[0] ? {bus.wdata[7:0], bus.wdata[15:0], 8'h00}
                           : {2{bus.wdata[15:0]}};
        end
        default: begin
          st_wstrb = 4'b1111;
          st_wdata = bus.wdata;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus the handshake strobes derived from the state.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid && req_is_mem) begin
          accept    = 1'b1;
          state_nxt = req_misalign ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        if (bus.dm_ack || timeout_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timeout counter: counts WAIT cycles, cleared everywhere else.
  always_ff @(posedge clk) begin
    if (!rst_n)                cnt <= '0;
    else if (state == ST_WAIT) cnt <= cnt + CNT_W'(1);
    else                       cnt <= '0;
  end

  // Capture the request and drive the memory port; outputs stay frozen in WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= 32'h0;
      op_q       <= 5'h0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= 32'h0;
      dm_wstrb_q <= 4'h0;
      dm_wdata_q <= 32'h0;
    end else if (accept) begin
      addr_q <= bus.addr;
      op_q   <= bus.mem_op;
      if (!req_misalign) begin
        dm_req_q   <= 1'b1;
        dm_we_q    <= req_is_store;
        dm_addr_q  <= {bus.addr[31:2], 2'b00};
        dm_wstrb_q <= st_wstrb;
        dm_wdata_q <= st_wdata;
      end
    end else if ((state == ST_WAIT) && (state_nxt == ST_RESP)) begin
      dm_req_q <= 1'b0;
    end
  end

  // Response registers; an ack beats a timeout landing in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dataout_q   <= 32'h0;
      resp_addr_q <= 32'h0;
      resp_op_q   <= 5'h0;
      resp_err_q  <= 1'b0;
    end else if ((state == ST_WAIT) && bus.dm_ack) begin
      dataout_q   <= (op_q[3] && !op_q[4] && !bus.dm_err) ? bus.dm_rdata : 32'h0;
      resp_addr_q <= addr_q;
      resp_op_q   <= op_q;
      resp_err_q  <= bus.dm_err;
    end else if (timeout_hit) begin
      dataout_q   <= 32'h0;
      resp_addr_q <= addr_q;
      resp_op_q   <= op_q;
      resp_err_q  <= 1'b1;
    end else if (accept && req_misalign) begin
      dataout_q   <= 32'h0;
      resp_addr_q <= bus.addr;
      resp_op_q   <= bus.mem_op;
      resp_err_q  <= 1'b0;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic resp_mis_q;

  // Every accepted request decides the flag for the response it produces.
  always_ff @(posedge clk) begin
    if (!rst_n)      resp_mis_q <= 1'b0;
    else if (accept) resp_mis_q <= req_misalign;
  end

  assign bus.resp_misalign = resp_mis_q;
`else
  assign bus.resp_misalign = 1'b0;
`endif

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.stall       = (bus.req_valid & ~req_ready) |
                           ((state != ST_IDLE) & ~resp_valid);
  assign bus.dm_req      = dm_req_q;
  assign bus.dm_we       = dm_we_q;
  assign bus.dm_addr     = dm_addr_q;
  assign bus.dm_wstrb    = dm_wstrb_q;
  assign bus.dm_wdata    = dm_wdata_q;
  assign bus.dataout     = dataout_q;
  assign bus.resp_addr   = resp_addr_q;
  assign bus.resp_mem_op = resp_op_q;
  assign bus.resp_err    = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl. Acts as pipeline and data memory, runs directed
// scenarios and a randomized sweep compared against a transaction-level model.
// Honors LSU_MISALIGN_CHECK_EN the same way the design does.
module tb_lsu_mem_ctrl;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        ready_at_req;
    logic        issued;
    logic        we;
    logic [31:0] daddr;
    logic [3:0]  strb;
    logic [31:0] dwdata;
    logic        stable;
    int          lat;
    logic        got_resp;
    logic [31:0] dout;
    logic [31:0] raddr;
    logic [4:0]  rop;
    logic        rerr;
    logic        rmis;
    logic        stall_ok;
    logic        pulse_ok;
    logic        req_at_resp;
    int          req_cycles;
    int          resp_cyc;
  } obs_t;

  // Transaction-level expectation: what one access should look like from outside.
  function automatic obs_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                                 input int ack_dly, input logic [31:0] rd, input logic er);
    obs_t e;
    int   sh, nb;
    logic st, ld, mis, tmo;
    e = '{default: '0};
    e.lat = -1;
    st = op[4];
    ld = op[3] & ~op[4];
    if (!st && !ld) return e;
    sh = int'(a[1:0]);
    nb = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (sh + nb) > 4;
`endif
    e.got_resp = 1'b1;
    e.raddr    = a;
    e.rop      = op;
    e.rmis     = mis;
    if (mis) begin
      e.lat = 0;
      return e;
    end
    e.issued = 1'b1;
    e.we     = st;
    e.daddr  = a & ~32'h3;
    if (st) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (nb == 4 || (lane >= sh && lane < sh + nb)) e.strb[lane] = 1'b1;
        if (nb == 1)      e.dwdata[8*lane +: 8] = wd[7:0];
        else if (nb == 4) e.dwdata[8*lane +: 8] = wd[8*lane +: 8];
        else if (lane >= (sh % 2))
          e.dwdata[8*lane +: 8] = wd[8*((lane - (sh % 2)) % 2) +: 8];
      end
    end
    tmo          = (ack_dly < 0) || (ack_dly >= TO);
    e.lat        = tmo ? TO : ack_dly + 1;
    e.req_cycles = e.lat;
    e.rerr       = tmo | er;
    e.dout       = (ld && !tmo && !er) ? rd : 32'h0;
    return e;
  endfunction

  // Drives one request starting at a negedge and plays memory; records what it saw.
  task automatic run_access(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_dly, input logic [31:0] rd, input logic er,
                            output obs_t o);
    int   idx;
    logic done;
    o = '{default: '0};
    o.lat = -1;
    o.stable = 1'b1;
    o.stall_ok = 1'b1;
    bus.req_valid = 1'b1;
    bus.mem_op    = op;
    bus.addr      = a;
    bus.wdata     = wd;
    #1;
    o.ready_at_req = bus.req_ready;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_op    = 5'h0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    idx  = 0;
    done = 1'b0;
    while (!done && idx < 200) begin
      bus.dm_ack = 1'b0;
      if (bus.resp_valid) begin
        o.got_resp    = 1'b1;
        o.lat         = idx;
        o.resp_cyc    = cyc;
        o.dout        = bus.dataout;
        o.raddr       = bus.resp_addr;
        o.rop         = bus.resp_mem_op;
        o.rerr        = bus.resp_err;
        o.rmis        = bus.resp_misalign;
        o.req_at_resp = bus.dm_req;
        if (bus.stall) o.stall_ok = 1'b0;
        @(negedge clk);
        o.pulse_ok = !bus.resp_valid;
        done = 1'b1;
      end else if (bus.dm_req) begin
        if (!o.issued) begin
          o.issued = 1'b1;
          o.we     = bus.dm_we;
          o.daddr  = bus.dm_addr;
          o.strb   = bus.dm_wstrb;
          o.dwdata = bus.dm_wdata;
        end else if (bus.dm_we !== o.we || bus.dm_addr !== o.daddr ||
                     bus.dm_wstrb !== o.strb || bus.dm_wdata !== o.dwdata) begin
          o.stable = 1'b0;
        end
        o.req_cycles++;
        if (!bus.stall) o.stall_ok = 1'b0;
        if (idx == ack_dly) begin
          bus.dm_ack   = 1'b1;
          bus.dm_rdata = rd;
          bus.dm_err   = er;
        end else begin
          bus.dm_rdata = $urandom;
          bus.dm_err   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        idx++;
      end else begin
        if (bus.stall) o.stall_ok = 1'b0;
        if (idx >= 3) done = 1'b1;
        else begin
          @(negedge clk);
          idx++;
        end
      end
    end
    bus.dm_ack = 1'b0;
    bus.dm_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.dm_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dm_req, bus.dm_we, bus.dm_wstrb, bus.resp_valid, bus.resp_err, bus.resp_misalign} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl got req=%b we=%b strb=%h rv=%b err=%b mis=%b required all 0",
               bus.dm_req, bus.dm_we, bus.dm_wstrb, bus.resp_valid, bus.resp_err, bus.resp_misalign);
    end
    checks++;
    if ({bus.dm_addr, bus.dm_wdata, bus.dataout, bus.resp_addr, bus.resp_mem_op} !== 133'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wd=%h dout=%h raddr=%h rop=%h required all 0",
               bus.dm_addr, bus.dm_wdata, bus.dataout, bus.resp_addr, bus.resp_mem_op);
    end
    checks++;
    if (bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got ready=%b stall=%b required 1/0", bus.req_ready, bus.stall);
    end
    bus.dm_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    obs_t o;
    run_access(5'b01010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, o);
    checks++;
    if (o.daddr !== 32'h100 || o.strb !== 4'h0 || o.we !== 1'b0) begin
      errors++;
      $display("FAIL t2_request got addr=%h strb=%h we=%b required 100/0/0", o.daddr, o.strb, o.we);
    end
    checks++;
    if (!o.got_resp || o.lat != 3 || !o.pulse_ok) begin
      errors++;
      $display("FAIL t2_timing got resp=%b lat=%0d pulse=%b required 1/3/1", o.got_resp, o.lat, o.pulse_ok);
    end
    checks++;
    if (o.dout !== 32'hDEADBEEF || o.raddr !== 32'h100 || o.rerr !== 1'b0) begin
      errors++;
      $display("FAIL t2_resp got dout=%h raddr=%h err=%b required deadbeef/100/0", o.dout, o.raddr, o.rerr);
    end
    checks++;
    if (!o.stall_ok || o.req_at_resp !== 1'b0) begin
      errors++;
      $display("FAIL t2_stall got stall_ok=%b req_at_resp=%b required 1/0", o.stall_ok, o.req_at_resp);
    end
  endtask

  task automatic test_store_byte();
    obs_t o;
    run_access(5'b10000, 32'h203, 32'h000000A5, 1, 32'h0, 1'b0, o);
    checks++;
    if (o.we !== 1'b1 || o.daddr !== 32'h200 || o.strb !== 4'b1000 || o.dwdata[31:24] !== 8'hA5) begin
      errors++;
      $display("FAIL t3_store_byte got we=%b addr=%h strb=%b wd=%h required 1/200/1000/a5xxxxxx",
               o.we, o.daddr, o.strb, o.dwdata);
    end
    checks++;
    if (!o.got_resp || o.rerr !== 1'b0 || o.dout !== 32'h0) begin
      errors++;
      $display("FAIL t3_resp got resp=%b err=%b dout=%h required 1/0/0", o.got_resp, o.rerr, o.dout);
    end
  endtask

  task automatic test_store_half();
    obs_t o;
    run_access(5'b10001, 32'h102, 32'hFFFF1234, 0, 32'h0, 1'b0, o);
    checks++;
    if (o.strb !== 4'b1100 || o.dwdata[31:16] !== 16'h1234 || o.daddr !== 32'h100) begin
      errors++;
      $display("FAIL t4_store_half got strb=%b wd=%h addr=%h required 1100/1234xxxx/100",
               o.strb, o.dwdata, o.daddr);
    end
    checks++;
    if (o.lat != 1) begin
      errors++;
      $display("FAIL t4_min_latency got %0d required 1", o.lat);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(5'b01010, 32'h300, 32'h0, -1, 32'h0, 1'b0, o);
    checks++;
    if (!o.got_resp || o.lat != TO || o.req_cycles != TO) begin
      errors++;
      $display("FAIL t5_timeout_time got resp=%b lat=%0d req_cycles=%0d required 1/%0d/%0d",
               o.got_resp, o.lat, o.req_cycles, TO, TO);
    end
    checks++;
    if (o.rerr !== 1'b1 || o.dout !== 32'h0 || o.req_at_resp !== 1'b0 || o.raddr !== 32'h300) begin
      errors++;
      $display("FAIL t5_timeout_resp got err=%b dout=%h dm_req=%b raddr=%h required 1/0/0/300",
               o.rerr, o.dout, o.req_at_resp, o.raddr);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(5'b01010, 32'h102, 32'h0, 0, 32'h55AA55AA, 1'b0, o);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++;
    if (o.issued !== 1'b0 || !o.got_resp || o.lat != 0 || o.rmis !== 1'b1 ||
        o.rerr !== 1'b0 || o.dout !== 32'h0) begin
      errors++;
      $display("FAIL t6_misalign got issued=%b resp=%b lat=%0d mis=%b err=%b dout=%h required 0/1/0/1/0/0",
               o.issued, o.got_resp, o.lat, o.rmis, o.rerr, o.dout);
    end
`else
    checks++;
    if (o.issued !== 1'b1 || o.daddr !== 32'h100 || o.rmis !== 1'b0 || o.dout !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL t6_misalign got issued=%b addr=%h mis=%b dout=%h required 1/100/0/55aa55aa",
               o.issued, o.daddr, o.rmis, o.dout);
    end
`endif
  endtask

  task automatic test_nop();
    obs_t o;
    run_access(5'b00110, 32'h444, 32'h0, 0, 32'h0, 1'b0, o);
    checks++;
    if (o.ready_at_req !== 1'b1 || o.issued !== 1'b0 || o.got_resp !== 1'b0 || !o.stall_ok) begin
      errors++;
      $display("FAIL nop_consumed got ready=%b issued=%b resp=%b stall_ok=%b required 1/0/0/1",
               o.ready_at_req, o.issued, o.got_resp, o.stall_ok);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    run_access(5'b01010, 32'h500, 32'h0, 0, 32'h11112222, 1'b0, o1);
    run_access(5'b10010, 32'h504, 32'hCAFEF00D, 0, 32'h0, 1'b1, o2);
    checks++;
    if (o2.ready_at_req !== 1'b1 || !o1.got_resp || !o2.got_resp || (o2.resp_cyc - o1.resp_cyc) != 3) begin
      errors++;
      $display("FAIL b2b_spacing got ready=%b resp=%b/%b spacing=%0d required 1/1/1/3",
               o2.ready_at_req, o1.got_resp, o2.got_resp, o2.resp_cyc - o1.resp_cyc);
    end
    checks++;
    if (o1.dout !== 32'h11112222 || o2.dout !== 32'h0 || o2.rerr !== 1'b1 || o2.strb !== 4'hF ||
        o2.dwdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL b2b_data got dout1=%h dout2=%h err2=%b strb2=%h wd2=%h required 11112222/0/1/f/cafef00d",
               o1.dout, o2.dout, o2.rerr, o2.strb, o2.dwdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic quiet;
    bus.req_valid = 1'b1;
    bus.mem_op    = 5'b01010;
    bus.addr      = 32'h40;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.dm_req !== 1'b1 || bus.req_ready !== 1'b0 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL pending_stall got req=%b ready=%b stall=%b required 1/0/1",
               bus.dm_req, bus.req_ready, bus.stall);
    end
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.dm_req !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.dataout !== 32'h0 || bus.resp_addr !== 32'h0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait got req=%b rv=%b ready=%b dout=%h raddr=%h err=%b required 0/0/1/0/0/0",
               bus.dm_req, bus.resp_valid, bus.req_ready, bus.dataout, bus.resp_addr, bus.resp_err);
    end
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.dm_req) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL reset_abandon got activity after reset, required none");
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [4:0]  op;
    logic [31:0] a, wd, rd;
    logic        er;
    int          kind, ack;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      op[1:0] = 2'($urandom_range(0, 2));
      op[2]   = 1'($urandom_range(0, 1));
      op[4:3] = (kind < 2) ? 2'b01 : (kind < 4) ? 2'b10 : (kind == 4) ? 2'b11 : 2'b00;
      a   = $urandom;
      wd  = $urandom;
      rd  = $urandom;
      er  = ($urandom_range(0, 3) == 0);
      ack = ($urandom_range(0, 9) == 0) ? 80 : $urandom_range(0, 4);
      e = model(op, a, wd, ack, rd, er);
      run_access(op, a, wd, ack, rd, er, o);
      checks++;
      if (o.issued !== e.issued || o.got_resp !== e.got_resp || o.lat != e.lat) begin
        errors++;
        $display("FAIL rnd%0d_flow op=%b addr=%h got issued=%b resp=%b lat=%0d required %b/%b/%0d",
                 n, op, a, o.issued, o.got_resp, o.lat, e.issued, e.got_resp, e.lat);
      end
      if (e.issued) begin
        checks++;
        if (o.we !== e.we || o.daddr !== e.daddr || o.strb !== e.strb || !o.stable ||
            o.req_cycles != e.req_cycles) begin
          errors++;
          $display("FAIL rnd%0d_request op=%b addr=%h got we=%b addr=%h strb=%b stable=%b cyc=%0d required %b/%h/%b/1/%0d",
                   n, op, a, o.we, o.daddr, o.strb, o.stable, o.req_cycles, e.we, e.daddr, e.strb, e.req_cycles);
        end
        if (e.we) begin
          checks++;
          if (o.dwdata !== e.dwdata) begin
            errors++;
            $display("FAIL rnd%0d_wdata op=%b addr=%h got %h required %h", n, op, a, o.dwdata, e.dwdata);
          end
        end
      end
      if (e.got_resp) begin
        checks++;
        if (o.dout !== e.dout || o.raddr !== e.raddr || o.rop !== e.rop ||
            o.rerr !== e.rerr || o.rmis !== e.rmis) begin
          errors++;
          $display("FAIL rnd%0d_resp got dout=%h addr=%h op=%b err=%b mis=%b required %h/%h/%b/%b/%b",
                   n, o.dout, o.raddr, o.rop, o.rerr, o.rmis, e.dout, e.raddr, e.rop, e.rerr, e.rmis);
        end
        checks++;
        if (!o.stall_ok || !o.pulse_ok || o.req_at_resp !== 1'b0 || o.ready_at_req !== 1'b1) begin
          errors++;
          $display("FAIL rnd%0d_handshake got stall_ok=%b pulse=%b dm_req=%b ready=%b required 1/1/0/1",
                   n, o.stall_ok, o.pulse_ok, o.req_at_resp, o.ready_at_req);
        end
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_op    = 5'h0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.dm_ack    = 1'b0;
    bus.dm_rdata  = 32'h0;
    bus.dm_err    = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_word();
    test_store_byte();
    test_store_half();
    test_timeout();
    test_misalign();
    test_nop();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
